nested_loop_counter: RTL

//  Multi-level loop-index generator for tiled accelerator dataflows. NumLoops

---
 rtl/nested_loop_counter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/nested_loop_counter.sv
// nested_loop_counter: multi-level loop-index generator for tiled dataflows.
// NumLoops chained ceiling counters (level 0 innermost) with ceiling and step
// latched per level at start. One index tuple is emitted per valid/ready
// handshake, with per-level wrap flags and a done pulse on the final tuple.
// Optional feature macro: NESTED_LOOP_PERF_EN adds stall_cnt_o, a saturating
// count of cycles spent with valid_o high and ready_i low.
module nested_loop_counter #(
  parameter int NumLoops = 3,
  parameter int Width    = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic                      clear_i,
  input  logic [NumLoops*Width-1:0] ceiling_i,
  input  logic [NumLoops*Width-1:0] step_i,
  input  logic                      ready_i,
  output logic                      valid_o,
  output logic [NumLoops*Width-1:0] count_o,
  output logic [NumLoops-1:0]       last_o,
  output logic                      busy_o,
  output logic                      done_o
`ifdef NESTED_LOOP_PERF_EN
  ,
  output logic [31:0]               stall_cnt_o
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [Width-1:0] One = {{(Width-1){1'b0}}, 1'b1};

  state_e                    state_reg, state_next;
  logic [NumLoops*Width-1:0] count_reg, count_next;
  logic [NumLoops*Width-1:0] ceil_reg, ceil_next;
  logic [NumLoops*Width-1:0] step_reg, step_next;
  logic [NumLoops*Width-1:0] count_adv;
  logic [NumLoops:0]         carry;      // carry[k]: levels 0..k-1 all at final value
  logic                      fire;
  logic                      done;

  assign valid_o = (state_reg == RUN);
  assign busy_o  = (state_reg == RUN);
  assign count_o = count_reg;
  assign fire    = valid_o && ready_i;
  assign done_o  = done;

  assign carry[0] = 1'b1;

  // Per-level final-value detection and advance value; ceiling 0 and step 0
  // are both treated as 1 so every level always makes progress.
  generate
    for (genvar gi = 0; gi < NumLoops; gi++) begin : g_level
      logic [Width-1:0] cnt, ceil_eff, step_eff;
      logic [Width:0]   sum;
      logic             is_final;

      assign cnt      = count_reg[gi*Width +: Width];
      assign ceil_eff = (ceil_reg[gi*Width +: Width] == '0) ? One : ceil_reg[gi*Width +: Width];
      assign step_eff = (step_reg[gi*Width +: Width] == '0) ? One : step_reg[gi*Width +: Width];
      // Compared one bit wider so count+step can never overflow silently.
      assign sum      = {1'b0, cnt} + {1'b0, step_eff};
      assign is_final = (sum >= {1'b0, ceil_eff});

      assign carry[gi+1] = carry[gi] && is_final;
      assign last_o[gi]  = valid_o && carry[gi+1];
      assign count_adv[gi*Width +: Width] = !carry[gi] ? cnt :
                                            (is_final ? '0 : sum[Width-1:0]);
    end
  endgenerate

  // State, counts and latched configuration registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      count_reg <= '0;
      ceil_reg  <= '0;
      step_reg  <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      ceil_reg  <= ceil_next;
      step_reg  <= step_next;
    end
  end

  // Next-state logic: clear beats start and handshake; done only on the final tuple.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    ceil_next  = ceil_reg;
    step_next  = step_reg;
    done       = 1'b0;
    if (clear_i) begin
      state_next = IDLE;
      count_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            ceil_next  = ceiling_i;
            step_next  = step_i;
            count_next = '0;
            state_next = RUN;
          end
        end
        RUN: begin
          if (fire) begin
            if (carry[NumLoops]) begin
              done       = 1'b1;
              state_next = IDLE;
              count_next = '0;
            end else begin
              count_next = count_adv;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

`ifdef NESTED_LOOP_PERF_EN
  logic [31:0] stall_cnt_reg;

  assign stall_cnt_o = stall_cnt_reg;

  // Saturating stall counter; restarts on an accepted start or an abort.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_reg <= '0;
    end else if (clear_i || (state_reg == IDLE && start_i)) begin
      stall_cnt_reg <= '0;
    end else if (valid_o && !ready_i && stall_cnt_reg != 32'hFFFF_FFFF) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end
`endif

endmodule
